ram_rw_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer that shares one single-port read/write RAM between two requesters. Each requester issues a read or write with a level request. The block grants one requester at a time and drives the RAM's select, address and write-data pins. It returns a one-cycle acknowledge, plus read data for reads. It sits between the requester logic and the RAM, whose clock and reset are the same `clk`/`reset` as this block.

---
 rtl/ram_rw_arbiter.sv | 109 ++++++++++
 tb/tb_ram_rw_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ram_rw_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port RAM between two requesters.
// Each grant runs IDLE -> ACCESS -> RESP: the RAM acts on the ACCESS->RESP edge and ack is returned in RESP.
module ram_rw_arbiter #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ram_sel,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state_reg;
    logic                  prio_reg;
    logic                  we_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [1:0]            gnt_reg;
    logic [1:0]            ack_reg;
    logic                  ram_sel_reg;

    logic                  win_next;
    logic                  we_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0] wdata_next;

    // A lone requester wins outright; a tie goes to the requester named by prio.
    always_comb begin
        win_next   = (req0 && req1) ? prio_reg : req1;
        we_next    = win_next ? we1    : we0;
        addr_next  = win_next ? addr1  : addr0;
        wdata_next = win_next ? wdata1 : wdata0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            prio_reg    <= 1'b0;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            gnt_reg     <= 2'b00;
            ack_reg     <= 2'b00;
            ram_sel_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req0 || req1) begin
                        state_reg   <= ACCESS;
                        prio_reg    <= ~win_next;
                        we_reg      <= we_next;
                        addr_reg    <= addr_next;
                        wdata_reg   <= wdata_next;
                        gnt_reg     <= win_next ? 2'b10 : 2'b01;
                        ram_sel_reg <= we_next;
                    end
                end
                ACCESS: begin
                    state_reg   <= RESP;
                    ram_sel_reg <= 1'b0;
                    ack_reg     <= gnt_reg;
                end
                RESP: begin
                    state_reg <= IDLE;
                    gnt_reg   <= 2'b00;
                    ack_reg   <= 2'b00;
                end
                default: begin
                    state_reg   <= IDLE;
                    gnt_reg     <= 2'b00;
                    ack_reg     <= 2'b00;
                    ram_sel_reg <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0     = gnt_reg[0];
    assign gnt1     = gnt_reg[1];
    assign ack0     = ack_reg[0];
    assign ack1     = ack_reg[1];
    assign ram_sel  = ram_sel_reg;
    assign ram_addr = addr_reg;
    assign ram_din  = wdata_reg;
    // ram_dout becomes valid on the same edge that raises ack, so read data is passed through.
    assign rdata    = ((|ack_reg) && !we_reg) ? ram_dout : '0;

endmodule

// File: tb/tb_ram_rw_arbiter.sv
// Directed bench for ram_rw_arbiter with a behavioural single-port RAM that
// shares clk/reset with the arbiter.
module tb_ram_rw_arbiter;
    localparam int AW = 2;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, ack0, ack1;
    logic [DW-1:0] rdata;
    logic          ram_sel;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_rw_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata(rdata), .ram_sel(ram_sel), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // RAM: reset clears it, sel=1 writes, sel=0 registers dout.
    logic [DW-1:0] mem [1<<AW];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
            ram_dout <= '0;
        end else if (ram_sel) begin
            mem[ram_addr] <= ram_din;
        end else begin
            ram_dout <= mem[ram_addr];
        end
    end

    always @(negedge clk)
        if (ack0 || ack1)
            $display("txn: ack0=%b ack1=%b rdata=%h t=%0t", ack0, ack1, rdata, $time);

    function automatic logic [4:0] ctl();
        return {gnt0, gnt1, ack0, ack1, ram_sel};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL reset_ctl: got %b exp 00000", ctl()); end
        checks++; if ({ram_addr, ram_din, rdata} !== '0) begin errors++; $display("FAIL reset_data: addr=%h din=%h rdata=%h exp 0", ram_addr, ram_din, rdata); end
    endtask

    task automatic test_write_then_read();
        do_reset();
        req0 = 1; we0 = 1; addr0 = 2'd2; wdata0 = 4'hA;
        step();
        checks++; if (ctl() !== 5'b10001) begin errors++; $display("FAIL wr_access_ctl: got %b exp 10001", ctl()); end
        checks++; if ({ram_addr, ram_din} !== {2'd2, 4'hA}) begin errors++; $display("FAIL wr_access_bus: addr=%h din=%h exp 2 a", ram_addr, ram_din); end
        req0 = 0;
        step();
        checks++; if (ctl() !== 5'b10100) begin errors++; $display("FAIL wr_resp_ctl: got %b exp 10100", ctl()); end
        checks++; if (rdata !== 4'h0) begin errors++; $display("FAIL wr_resp_rdata: got %h exp 0", rdata); end
        step();
        checks++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL wr_idle_ctl: got %b exp 00000", ctl()); end
        req0 = 1; we0 = 0; addr0 = 2'd2;
        step();
        checks++; if (ctl() !== 5'b10000) begin errors++; $display("FAIL rd_access_ctl: got %b exp 10000", ctl()); end
        req0 = 0;
        step();
        checks++; if (ctl() !== 5'b10100) begin errors++; $display("FAIL rd_resp_ctl: got %b exp 10100", ctl()); end
        checks++; if (rdata !== 4'hA) begin errors++; $display("FAIL rd_rdata: got %h exp a", rdata); end
        step();
    endtask

    task automatic test_simultaneous_read();
        do_reset();
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0;
        step();
        checks++; if (ctl() !== 5'b10000) begin errors++; $display("FAIL sim_first_gnt: got %b exp 10000", ctl()); end
        req0 = 0;
        step();
        checks++; if (ctl() !== 5'b10100 || rdata !== 4'h0) begin errors++; $display("FAIL sim_ack0: ctl=%b rdata=%h exp 10100 0", ctl(), rdata); end
        step();
        checks++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL sim_idle: got %b exp 00000", ctl()); end
        step();
        checks++; if (ctl() !== 5'b01000) begin errors++; $display("FAIL sim_second_gnt: got %b exp 01000", ctl()); end
        req1 = 0;
        step();
        checks++; if (ctl() !== 5'b01010 || rdata !== 4'h0) begin errors++; $display("FAIL sim_ack1: ctl=%b rdata=%h exp 01010 0", ctl(), rdata); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp;
        do_reset();
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 2'd1; addr1 = 2'd3;
        for (int i = 1; i <= 12; i++) begin
            step();
            case (i % 6)
                1: exp = 5'b10000;
                2: exp = 5'b10100;
                4: exp = 5'b01000;
                5: exp = 5'b01010;
                default: exp = 5'b00000;
            endcase
            checks++; if (ctl() !== exp) begin errors++; $display("FAIL b2b_cycle%0d: got %b exp %b", i, ctl(), exp); end
            checks++; if (gnt0 && gnt1) begin errors++; $display("FAIL b2b_gnt_excl%0d: gnt0=%b gnt1=%b exp not both", i, gnt0, gnt1); end
            if (i == 11) begin req0 = 0; req1 = 0; end
        end
        step();
        checks++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL b2b_drained: got %b exp 00000", ctl()); end
    endtask

    task automatic test_prio1_write_read();
        do_reset();
        req0 = 1; we0 = 0; addr0 = 0;
        step();
        req0 = 0;
        step();
        step();
        req0 = 1; we0 = 0; addr0 = 2'd3;
        req1 = 1; we1 = 1; addr1 = 2'd3; wdata1 = 4'h5;
        step();
        checks++; if (ctl() !== 5'b01001) begin errors++; $display("FAIL p1_wr_access: got %b exp 01001", ctl()); end
        checks++; if ({ram_addr, ram_din} !== {2'd3, 4'h5}) begin errors++; $display("FAIL p1_wr_bus: addr=%h din=%h exp 3 5", ram_addr, ram_din); end
        req1 = 0;
        step();
        checks++; if (ctl() !== 5'b01010 || rdata !== 4'h0) begin errors++; $display("FAIL p1_wr_ack1: ctl=%b rdata=%h exp 01010 0", ctl(), rdata); end
        step();
        step();
        checks++; if (ctl() !== 5'b10000) begin errors++; $display("FAIL p1_rd_gnt0: got %b exp 10000", ctl()); end
        req0 = 0;
        step();
        checks++; if (ctl() !== 5'b10100 || rdata !== 4'h5) begin errors++; $display("FAIL p1_rd_ack0: ctl=%b rdata=%h exp 10100 5", ctl(), rdata); end
        step();
    endtask

    task automatic test_reset_during_access();
        do_reset();
        req0 = 1; we0 = 1; addr0 = 2'd1; wdata0 = 4'hF;
        step();
        checks++; if (ctl() !== 5'b10001) begin errors++; $display("FAIL rst_wr_access: got %b exp 10001", ctl()); end
        reset = 1; req0 = 0;
        step();
        reset = 0;
        checks++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL rst_ctl: got %b exp 00000", ctl()); end
        checks++; if ({ram_addr, ram_din, rdata} !== '0) begin errors++; $display("FAIL rst_data: addr=%h din=%h rdata=%h exp 0", ram_addr, ram_din, rdata); end
        step();
        checks++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL rst_no_ack: got %b exp 00000", ctl()); end
        req0 = 1; we0 = 0; addr0 = 2'd1;
        step();
        req0 = 0;
        step();
        checks++; if (ctl() !== 5'b10100 || rdata !== 4'h0) begin errors++; $display("FAIL rst_readback: ctl=%b rdata=%h exp 10100 0", ctl(), rdata); end
        step();
    endtask

    task automatic test_idle();
        req0 = 0; req1 = 0; we0 = 1; we1 = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (ctl() !== 5'b00000 || rdata !== 4'h0) begin errors++; $display("FAIL idle%0d: ctl=%b rdata=%h exp 00000 0", i, ctl(), rdata); end
        end
    endtask

    initial begin
        test_reset();
        test_write_then_read();
        test_simultaneous_read();
        test_back_to_back();
        test_prio1_write_read();
        test_reset_during_access();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
